// File: rtl/uart_transmitter_if.sv
// Byte/handshake bundle between the UART receiver (master) and transmitter (slave).
interface uart_transmitter_if;
    logic       ENABLE;
    logic       CONECT_PRIZNAC;
    logic [7:0] word_receiver;
    logic       TX;
    logic       BUSY;
    logic       priznak_end_transmitter;

    modport master (
        output ENABLE,
        output CONECT_PRIZNAC,
        output word_receiver,
        input  TX,
        input  BUSY,
        input  priznak_end_transmitter
    );

    modport slave (
        input  ENABLE,
        input  CONECT_PRIZNAC,
        input  word_receiver,
        output TX,
        output BUSY,
        output priznak_end_transmitter
    );
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter paced by the receiver's ENABLE strobe, with a
// level handshake (CONECT_PRIZNAC / priznak_end_transmitter) per byte.
module uart_transmitter #(
    parameter int unsigned OVERSAMPLE = 5,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                clk,
    input  logic                res,
    uart_transmitter_if.slave   tx_if
);

    localparam int unsigned TICK_W   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned STOP_LEN = STOP_BITS * OVERSAMPLE;
    localparam int unsigned STOP_W   = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_e;

    state_e              state_q;
    logic [7:0]          shift_q;
    logic [TICK_W-1:0]   tick_q;
    logic [2:0]          bit_q;
    logic [STOP_W-1:0]   stop_q;
    logic                tx_q;
    logic                busy_q;
    logic                end_q;

    // Frame sequencer; TX/BUSY/end flag are updated on the same edge as the state they describe.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= S_IDLE;
            shift_q <= 8'h00;
            tick_q  <= '0;
            bit_q   <= 3'd0;
            stop_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (tx_if.CONECT_PRIZNAC) begin
                        shift_q <= tx_if.word_receiver;
                        tick_q  <= '0;
                        bit_q   <= 3'd0;
                        stop_q  <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_START;
                    end
                end

                S_START: begin
                    if (tx_if.ENABLE) begin
                        if (tick_q == TICK_LAST) begin
                            tick_q  <= '0;
                            tx_q    <= shift_q[0];
                            state_q <= S_DATA;
                        end else begin
                            tick_q <= tick_q + TICK_W'(1);
                        end
                    end
                end

                S_DATA: begin
                    if (tx_if.ENABLE) begin
                        if (tick_q == TICK_LAST) begin
                            tick_q  <= '0;
                            shift_q <= {1'b0, shift_q[7:1]};
                            bit_q   <= bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                tx_q    <= 1'b1;
                                state_q <= S_STOP;
                            end else begin
                                tx_q <= shift_q[1];
                            end
                        end else begin
                            tick_q <= tick_q + TICK_W'(1);
                        end
                    end
                end

                S_STOP: begin
                    tx_q <= 1'b1;
                    if (tx_if.ENABLE) begin
                        if (stop_q == STOP_LAST) begin
                            stop_q  <= '0;
                            end_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            stop_q <= stop_q + STOP_W'(1);
                        end
                    end
                end

                S_DONE: begin
                    tx_q <= 1'b1;
                    // Wait for the receiver to withdraw its flag so a held flag never retransmits.
                    if (!tx_if.CONECT_PRIZNAC) begin
                        end_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    end_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_if.TX                      = tx_q;
    assign tx_if.BUSY                    = busy_q;
    assign tx_if.priznak_end_transmitter = end_q;

endmodule
